biriscv_dmem_responder: RTL and testbench

- Responder (memory side) of the core's mem_d_* data-memory interface: accepts tagged load/store/cache-maintenance requests, performs them against an internal word array, and returns tagged acks after a fixed latency.
- Replaces the simple combinational data path of the memory model in fuzzing tops, so the core's outstanding-request, tag and error paths are exercised.

---
 rtl/biriscv_dmem_pkg.sv | 36 +++
 rtl/biriscv_dmem_resp_pipe.sv | 28 ++
 rtl/biriscv_dmem.sv | 126 ++++++++++++
 tb/tb_biriscv_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_dmem_pkg.sv
// Shared types and constants for the biriscv data-memory responder.
// BIRISCV_DMEM_STALL_EN uses the LFSR constants and helper defined here.
package biriscv_dmem_pkg;

  localparam int TAG_W  = 11;
  localparam int DATA_W = 32;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef struct packed {
    logic              valid;
    logic              error;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } resp_entry_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {^(state & LFSR_TAPS), state[15:1]};
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [3:0]        byte_en
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/biriscv_dmem_resp_pipe.sv
// Fixed-latency response delay line; a synchronous clear drops every
// in-flight entry so nothing queued before reset is ever acked.
module biriscv_dmem_resp_pipe
  import biriscv_dmem_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  resp_entry_t push_entry,
  output resp_entry_t head_entry
);

  resp_entry_t stage_q [LATENCY];

  // Empty cycles shift in an all-zero entry, so idle outputs read as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= push_entry;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign head_entry = stage_q[LATENCY-1];

endmodule

// File: rtl/biriscv_dmem.sv
// Memory-side responder for the mem_d_* interface with tagged, in-order acks.
// Define BIRISCV_DMEM_STALL_EN to inject LFSR-driven accept backpressure.
module biriscv_dmem_responder
  import biriscv_dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h80000000,
  parameter int          ADDR_W          = 14,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          OUTSTANDING_W   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      mem_d_addr_i,
  input  logic [31:0]      mem_d_data_wr_i,
  input  logic             mem_d_rd_i,
  input  logic [3:0]       mem_d_wr_i,
  input  logic             mem_d_cacheable_i,
  input  logic [TAG_W-1:0] mem_d_req_tag_i,
  input  logic             mem_d_invalidate_i,
  input  logic             mem_d_writeback_i,
  input  logic             mem_d_flush_i,
  output logic             mem_d_accept_o,
  output logic             mem_d_ack_o,
  output logic             mem_d_error_o,
  output logic [TAG_W-1:0] mem_d_resp_tag_o,
  output logic [31:0]      mem_d_data_rd_o
);

  localparam int                       DEPTH   = 1 << ADDR_W;
  localparam logic [OUTSTANDING_W-1:0] MAX_CNT = OUTSTANDING_W'(MAX_OUTSTANDING);

  logic [31:0]              mem_q [DEPTH];
  logic [OUTSTANDING_W-1:0] outstanding_q;
  logic                     req;
  logic                     fire;
  logic                     is_store;
  logic                     is_access;
  logic                     in_range;
  logic                     slot_free;
  logic                     stall;
  logic [31:0]              offset;
  logic [ADDR_W-1:0]        word_idx;
  logic [31:0]              rd_word;
  resp_entry_t              push_entry;
  resp_entry_t              head_entry;
  logic                     unused_cacheable;

  assign unused_cacheable = mem_d_cacheable_i;

  assign req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i
             | mem_d_writeback_i | mem_d_flush_i;
  assign is_store  = |mem_d_wr_i;
  assign is_access = mem_d_rd_i | is_store;

  // Shift test rather than a compare so a window of 2^32 bytes cannot overflow
  assign offset   = mem_d_addr_i - BASE_ADDR;
  assign in_range = (offset >> (ADDR_W + 2)) == 32'd0;
  assign word_idx = offset[ADDR_W+1:2];
  assign rd_word  = mem_q[word_idx];

`ifdef BIRISCV_DMEM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Only the registered count gates accept; an ack frees its slot next cycle
  assign slot_free      = outstanding_q < MAX_CNT;
  assign mem_d_accept_o = ~rst_i & slot_free & ~stall;
  assign fire           = req & mem_d_accept_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      case ({fire, head_entry.valid})
        2'b10:   outstanding_q <= outstanding_q + OUTSTANDING_W'(1);
        2'b01:   outstanding_q <= outstanding_q - OUTSTANDING_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Array contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    if (fire && is_store && in_range) begin
      mem_q[word_idx] <= merge_bytes(rd_word, mem_d_data_wr_i, mem_d_wr_i);
    end
  end

  // Stores also return the pre-write word; maintenance-only returns zero
  always_comb begin
    push_entry = '0;
    if (fire) begin
      push_entry.valid = 1'b1;
      push_entry.tag   = mem_d_req_tag_i;
      if (is_access) begin
        if (in_range) push_entry.data  = rd_word;
        else          push_entry.error = 1'b1;
      end
    end
  end

  biriscv_dmem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk        (clk_i),
    .rst        (rst_i),
    .push_entry (push_entry),
    .head_entry (head_entry)
  );

  assign mem_d_ack_o      = head_entry.valid;
  assign mem_d_error_o    = head_entry.error;
  assign mem_d_resp_tag_o = head_entry.tag;
  assign mem_d_data_rd_o  = head_entry.data;

endmodule

// File: tb/tb_biriscv_dmem_responder.sv
// Scoreboard bench for biriscv_dmem_responder; also models the
// BIRISCV_DMEM_STALL_EN backpressure LFSR when that macro is defined.
module tb_biriscv_dmem_responder;
  import biriscv_dmem_pkg::*;

  localparam logic [31:0] BASE     = 32'h80000000;
  localparam int          ADDR_W   = 14;
  localparam int          LATENCY  = 2;
  localparam int          MAX_OUT  = 2;
  localparam int          OUT_W    = 3;
  localparam int          MAX_WAIT = 64;
`ifdef BIRISCV_DMEM_STALL_EN
  localparam int          N_RANDOM = 1000;
`else
  localparam int          N_RANDOM = 200;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      addr = '0;
  logic [31:0]      wdata = '0;
  logic             rd = 1'b0;
  logic [3:0]       wr = '0;
  logic             cacheable = 1'b0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             inval = 1'b0;
  logic             wback = 1'b0;
  logic             flush = 1'b0;
  logic             accept;
  logic             ack;
  logic             error;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      rdata;

  always #5 clk = ~clk;

  biriscv_dmem_responder #(
    .BASE_ADDR       (BASE),
    .ADDR_W          (ADDR_W),
    .LATENCY         (LATENCY),
    .MAX_OUTSTANDING (MAX_OUT),
    .OUTSTANDING_W   (OUT_W)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .mem_d_addr_i       (addr),
    .mem_d_data_wr_i    (wdata),
    .mem_d_rd_i         (rd),
    .mem_d_wr_i         (wr),
    .mem_d_cacheable_i  (cacheable),
    .mem_d_req_tag_i    (req_tag),
    .mem_d_invalidate_i (inval),
    .mem_d_writeback_i  (wback),
    .mem_d_flush_i      (flush),
    .mem_d_accept_o     (accept),
    .mem_d_ack_o        (ack),
    .mem_d_error_o      (error),
    .mem_d_resp_tag_o   (resp_tag),
    .mem_d_data_rd_o    (rdata)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             error;
    logic [31:0]      data;
    bit               chk_data;
    int               due;
  } exp_t;

  exp_t        sb[$];
  exp_t        head;
  logic [31:0] mem_m [int];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          model_cnt = 0;
  int          stall_seen = 0;
  bit          fire_now = 0;
  bit          ack_now = 0;
  logic [15:0] lfsr_m = 16'hACE1;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", name, observed, expected, cyc);
    end
  endtask

  // Reference state: outstanding count, stall LFSR, reset flush of the scoreboard
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      model_cnt = 0;
      lfsr_m    = 16'hACE1;
      sb.delete();
    end else begin
      model_cnt = model_cnt + int'(fire_now) - int'(ack_now);
      lfsr_m    = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end
    fire_now = 0;
    ack_now  = 0;
  end

  always @(negedge clk) begin
    ack_now = (ack === 1'b1);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      head = sb.pop_front();
      checkOutput("ack", ack, 1);
      checkOutput("resp_tag", resp_tag, head.tag);
      checkOutput("resp_error", error, head.error);
      if (head.chk_data) checkOutput("resp_data", rdata, head.data);
    end else if (ack !== 1'b0) begin
      checkOutput("spurious_ack", ack, 0);
    end
  end

  function automatic bit expected_accept();
    bit a;
    a = !rst && (model_cnt < MAX_OUT);
`ifdef BIRISCV_DMEM_STALL_EN
    a = a && (lfsr_m[1:0] != 2'b00);
`endif
    return a;
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic r,
                               input logic [3:0] w, input logic [2:0] maint, input logic [TAG_W-1:0] t);
    int          waited;
    bit          done;
    exp_t        e;
    logic [31:0] off;
    int          idx;
    logic [31:0] word;
    waited = 0;
    done   = 0;
    addr = a; wdata = d; rd = r; wr = w; req_tag = t;
    {inval, wback, flush} = maint;
    cacheable = $urandom_range(1, 0) == 1;
    while (!done) begin
      @(negedge clk);
      #1;
      checkOutput("accept", accept, expected_accept());
      if (accept === 1'b1) begin
        done     = 1;
        fire_now = 1;
        off      = a - BASE;
        idx      = int'(off >> 2);
        e.tag = t; e.error = 1'b0; e.data = '0; e.chk_data = 1; e.due = cyc + LATENCY;
        if (r || w != 4'h0) begin
          if (off >= (32'd4 << ADDR_W)) begin
            e.error = 1'b1;
          end else begin
            e.chk_data = mem_m.exists(idx);
            word = e.chk_data ? mem_m[idx] : 32'h0;
            e.data = word;
            if (w != 4'h0) begin
              for (int b = 0; b < 4; b++) if (w[b]) word[8*b +: 8] = d[8*b +: 8];
              if (w == 4'hF || mem_m.exists(idx)) mem_m[idx] = word;
            end
          end
        end
        sb.push_back(e);
      end else begin
        stall_seen++;
        waited++;
        if (waited > MAX_WAIT) begin
          checkOutput("accept_wait", waited, MAX_WAIT);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    rd = 0; wr = '0; {inval, wback, flush} = 3'b000;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checkOutput({name, "_ack"}, ack, 0);
    checkOutput({name, "_error"}, error, 0);
    checkOutput({name, "_tag"}, resp_tag, 0);
    checkOutput({name, "_data"}, rdata, 0);
  endtask

  initial begin
    int          stall_before;
    int          drain;
    int          op;
    logic [31:0] a;
    logic [3:0]  w;

    $display("[TB] start");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("accept_in_reset", accept, 0);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst = 0;

    // Full store then load of the same word in the following cycle
    applyStimulus(32'h80000010, 32'hDEADBEEF, 0, 4'hF, 3'b000, 11'h005);
    applyStimulus(32'h80000010, 32'h0,        1, 4'h0, 3'b000, 11'h006);

    // Byte-lane merge
    applyStimulus(32'h80000020, 32'h11223344, 0, 4'hF,    3'b000, 11'h007);
    applyStimulus(32'h80000020, 32'h0000AA00, 0, 4'b0010, 3'b000, 11'h008);
    applyStimulus(32'h80000022, 32'h0,        1, 4'h0,    3'b000, 11'h009);
    idle(LATENCY + 1);
    checkOutput("byte_merge_model", mem_m[8], 32'h1122AA44);

    // Window edges: stores outside must not alias onto word 0 or the last word
    applyStimulus(BASE,                32'h0BADF00D, 0, 4'hF, 3'b000, 11'h010);
    applyStimulus(BASE + 32'h0000FFFC, 32'h5A5A5A5A, 0, 4'hF, 3'b000, 11'h011);
    applyStimulus(BASE + 32'h00010000, 32'hFFFFFFFF, 0, 4'hF, 3'b000, 11'h012);
    applyStimulus(32'h7FFFFFFC,        32'hFFFFFFFF, 0, 4'hF, 3'b000, 11'h013);
    applyStimulus(BASE + 32'h00010000, 32'h0,        1, 4'h0, 3'b000, 11'h014);
    applyStimulus(32'h7FFFFFFC,        32'h0,        1, 4'h0, 3'b000, 11'h015);
    applyStimulus(BASE,                32'h0,        1, 4'h0, 3'b000, 11'h016);
    applyStimulus(BASE + 32'h0000FFFC, 32'h0,        1, 4'h0, 3'b000, 11'h017);

    // Continuous loads run into the outstanding limit
    stall_before = stall_seen;
    for (int i = 0; i < 6; i++) applyStimulus(32'h80000010, 32'h0, 1, 4'h0, 3'b000, 11'(32'h100 + i));
    checkOutput("backpressure_seen", 64'(stall_seen > stall_before), 1);

    applyStimulus(32'h80000040, 32'h0, 0, 4'h0, 3'b001, 11'h3FF);
    applyStimulus(32'h80000044, 32'h0, 0, 4'h0, 3'b100, 11'h3FE);
    idle(LATENCY + 2);

    // Reset while a load is in flight: it must vanish
    applyStimulus(32'h80000010, 32'h0, 1, 4'h0, 3'b000, 11'h055);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_outputs_zero("post_reset");
    idle(LATENCY + 3);

    for (int k = 0; k < 8; k++) applyStimulus(BASE + 32'h200 + 32'(4 * k), $urandom, 0, 4'hF, 3'b000, 11'(k));
    for (int i = 0; i < N_RANDOM; i++) begin
      op = $urandom_range(3, 0);
      a  = BASE + 32'h200 + 32'(4 * $urandom_range(7, 0)) + 32'($urandom_range(3, 0));
      w  = 4'($urandom_range(15, 1));
      case (op)
        0: applyStimulus(a, 32'h0, 1, 4'h0, 3'b000, 11'(i));
        1: applyStimulus(a, $urandom, $urandom_range(1, 0) == 1, w, 3'b000, 11'(i));
        2: applyStimulus(a, 32'h0, 0, 4'h0, 3'($urandom_range(7, 1)), 11'(i));
        default: applyStimulus(BASE + 32'h00010000 + 32'(4 * $urandom_range(255, 0)), 32'h0, 1, 4'h0, 3'b000, 11'(i));
      endcase
    end

    drain = 0;
    while (sb.size() > 0 && drain < 100) begin
      @(posedge clk);
      drain++;
    end
    checkOutput("drain_left", sb.size(), 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
